// File: rtl/serializer_pkg.sv
// Shared types and constants for the bit serializer.
// Build option: define SERIALIZER_LSB_FIRST_EN to emit words LSB first (default MSB first).
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned DefaultWidth   = 8;
  localparam logic        DefaultIdleBit = 1'b0;

  // Bit-counter width needed to hold indices 0..w-1.
  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and emits one bit
// per clock, back-to-back words with no gap so downstream sequence matching spans words.
// Build option: SERIALIZER_LSB_FIRST_EN selects LSB-first emission (register shifts right);
// without it words go out MSB first (register shifts left).
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter logic        IDLE_BIT = DefaultIdleBit
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             data_out,
  output logic             data_out_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    CntW = cnt_w(WIDTH);
  localparam logic [CntW-1:0] Last = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             on_last;
  logic             xfer;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] sreg_shifted;

  // Bit-order selection: sreg keeps the currently shown bit at the emitting end.
`ifdef SERIALIZER_LSB_FIRST_EN
  assign first_bit    = load_data[0];
  assign next_bit     = sreg_q[1];
  assign sreg_shifted = sreg_q >> 1;
`else
  assign first_bit    = load_data[WIDTH-1];
  assign next_bit     = sreg_q[WIDTH-2];
  assign sreg_shifted = sreg_q << 1;
`endif

  // Ready while idle or while the last bit of the current word is showing.
  always_comb begin
    on_last    = (state_q == SHIFT) && (count_q == Last);
    load_ready = (state_q == IDLE) || on_last;
    xfer       = load_valid && load_ready;
  end

  // Next-state, counter, shift register and registered-output decode.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sreg_d  = sreg_q;
    dout_d  = IDLE_BIT;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    if (xfer) begin
      // Fresh load, or gapless reload straight off the last bit.
      state_d = SHIFT;
      count_d = '0;
      sreg_d  = load_data;
      dout_d  = first_bit;
      valid_d = 1'b1;
      busy_d  = 1'b1;
    end else if (state_q == SHIFT && !on_last) begin
      state_d = SHIFT;
      count_d = count_q + CntW'(1);
      sreg_d  = sreg_shifted;
      dout_d  = next_bit;
      valid_d = 1'b1;
      busy_d  = 1'b1;
      done_d  = (count_d == Last);
    end else if (on_last) begin
      state_d = IDLE;
      count_d = '0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      sreg_q  <= '0;
      dout_q  <= IDLE_BIT;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sreg_q  <= sreg_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: directed tables plus random traffic against a
// queue-based reference model of the emitted bit stream.
module tb_bit_serializer;

  localparam int unsigned W        = 8;
  localparam logic        IdleBit  = 1'b0;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         data_out;
  logic         data_out_valid;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  bit m_q[$];        // bits still to be shown; front is the bit on data_out
  bit model_ok = 0;  // model meaningful once a reset edge has been applied

  bit_serializer #(
    .WIDTH   (W),
    .IDLE_BIT(IdleBit)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_data     (load_data),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check ready before the edge and outputs after it.
  task automatic cycle(input logic r, input logic lv, input logic [W-1:0] ld);
    bit rdy;
    rst        = r;
    load_valid = lv;
    load_data  = ld;
    #1;
    rdy = (m_q.size() <= 1);
    if (model_ok) chk("model_ready", {31'd0, load_ready}, {31'd0, rdy});
    @(posedge clk);
    if (!r) begin
      m_q.delete();
      model_ok = 1;
    end else if (model_ok) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      if (lv && rdy) begin
`ifdef SERIALIZER_LSB_FIRST_EN
        for (int i = 0; i < int'(W); i++) m_q.push_back(ld[i]);
`else
        for (int i = int'(W) - 1; i >= 0; i--) m_q.push_back(ld[i]);
`endif
      end
    end
    #1;
    if (model_ok) begin
      chk("model_valid", {31'd0, data_out_valid}, {31'd0, m_q.size() > 0});
      chk("model_busy", {31'd0, busy}, {31'd0, m_q.size() > 0});
      chk("model_done", {31'd0, done}, {31'd0, m_q.size() == 1});
      chk("model_dout", {31'd0, data_out},
          {31'd0, (m_q.size() > 0) ? logic'(m_q[0]) : IdleBit});
    end
  endtask

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] msb_seq;  // expected emission, first bit in bit W-1
    logic [W-1:0] lsb_seq;
  } vec_t;

  vec_t vecs[4];
  logic [15:0] b2b_exp;
  logic [W-1:0] seq;

  initial begin
    vecs[0] = '{word: 8'b10101101, msb_seq: 8'b10101101, lsb_seq: 8'b10110101};
    vecs[1] = '{word: 8'h01,       msb_seq: 8'h01,       lsb_seq: 8'h80};
    vecs[2] = '{word: 8'hF0,       msb_seq: 8'hF0,       lsb_seq: 8'h0F};
    vecs[3] = '{word: 8'h6B,       msb_seq: 8'h6B,       lsb_seq: 8'hD6};

    rst = 1'b0; load_valid = 1'b0; load_data = '0;
    @(negedge clk);

    // Reset hold with load_valid high: nothing accepted.
    cycle(1'b0, 1'b1, 8'hFF);
    cycle(1'b0, 1'b1, 8'hFF);
    chk("rst_ready", {31'd0, load_ready}, 32'd1);
    chk("rst_dout", {31'd0, data_out}, {31'd0, IdleBit});
    chk("rst_valid", {31'd0, data_out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    // Single-word table.
    foreach (vecs[k]) begin
`ifdef SERIALIZER_LSB_FIRST_EN
      seq = vecs[k].lsb_seq;
`else
      seq = vecs[k].msb_seq;
`endif
      cycle(1'b1, 1'b1, vecs[k].word);
      for (int i = 0; i < int'(W); i++) begin
        chk("word_bit", {31'd0, data_out}, {31'd0, seq[W-1-i]});
        chk("word_valid", {31'd0, data_out_valid}, 32'd1);
        chk("word_done", {31'd0, done}, {31'd0, i == int'(W) - 1});
        cycle(1'b1, 1'b0, $urandom());
      end
      chk("word_idle_dout", {31'd0, data_out}, {31'd0, IdleBit});
      chk("word_idle_valid", {31'd0, data_out_valid}, 32'd0);
    end

    // Back-to-back A5, 3C (both bit-palindromes, so same stream in either build).
    b2b_exp = 16'hA53C;
    cycle(1'b1, 1'b1, 8'hA5);
    for (int c = 1; c <= 16; c++) begin
      chk("b2b_bit", {31'd0, data_out}, {31'd0, b2b_exp[16-c]});
      chk("b2b_valid", {31'd0, data_out_valid}, 32'd1);
      chk("b2b_done", {31'd0, done}, {31'd0, c == 8 || c == 16});
      chk("b2b_ready", {31'd0, load_ready}, {31'd0, c == 8 || c == 16});
      cycle(1'b1, c < 16, 8'h3C);
    end
    chk("b2b_end_valid", {31'd0, data_out_valid}, 32'd0);

    // Mid-word reset: abort after 3 bits, then accept a new word immediately.
    cycle(1'b1, 1'b1, 8'hFF);
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    chk("mid_rst_valid", {31'd0, data_out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_dout", {31'd0, data_out}, {31'd0, IdleBit});
    chk("mid_rst_ready", {31'd0, load_ready}, 32'd1);
    cycle(1'b1, 1'b1, 8'h80);
    chk("post_rst_valid", {31'd0, data_out_valid}, 32'd1);
    for (int i = 0; i < int'(W) - 1; i++) begin
      chk("post_rst_nodone", {31'd0, done}, 32'd0);
      cycle(1'b1, 1'b0, 8'h00);
    end
    chk("post_rst_done", {31'd0, done}, 32'd1);

    // Stall: five idle cycles, then a fresh word restarts at count 0.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, $urandom());
      chk("stall_busy", {31'd0, busy}, 32'd0);
      chk("stall_valid", {31'd0, data_out_valid}, 32'd0);
    end
    cycle(1'b1, 1'b1, 8'hC3);
    for (int i = 0; i < int'(W); i++) begin
      chk("stall_reload_done", {31'd0, done}, {31'd0, i == int'(W) - 1});
      cycle(1'b1, 1'b0, 8'h00);
    end

    // Random traffic against the queue model.
    for (int n = 0; n < 1500; n++) begin
      cycle(($urandom_range(0, 60) != 0), ($urandom_range(0, 3) != 0), $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
